// File: rtl/exec_alu_unit_if.sv
// exec_alu_unit_if
// Groups the execute-stage operand, decode and result signals into one bundle.
//   master modport : the control/datapath side that supplies operands and reads results
//   slave modport  : the exec_alu_unit itself
// Signals:
//   alu_op, funct            decode inputs (ALUOp, instruction[5:0])
//   operand_a, operand_b     ALU operands
//   add_a, add_b             free-standing adder operands
//   in_valid                 qualifies operands for the registered stage
//   alu_sel, alu_result, zf  combinational ALU outputs
//   add_result               combinational adder output
//   result_q, zf_q, out_valid registered copy of the ALU outputs
interface exec_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             in_valid;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             zf;
    logic [WIDTH-1:0] add_result;
    logic [WIDTH-1:0] result_q;
    logic             zf_q;
    logic             out_valid;

    modport master (
        output alu_op, funct, operand_a, operand_b, add_a, add_b, in_valid,
        input  alu_sel, alu_result, zf, add_result, result_q, zf_q, out_valid
    );

    modport slave (
        input  alu_op, funct, operand_a, operand_b, add_a, add_b, in_valid,
        output alu_sel, alu_result, zf, add_result, result_q, zf_q, out_valid
    );
endinterface

// File: rtl/exec_alu_unit.sv
// exec_alu_unit
// Execute-stage arithmetic block of the single-cycle MIPS-style datapath:
// ALU control decoder, 32-bit ALU with zero flag, and a free-standing adder
// (PC+4 / branch target). Datapath outputs are combinational; a registered
// copy of result/zero is kept for pipelined consumers.
// Ports:
//   clk    rising-edge clock for the registered stage
//   reset  synchronous, active-high; clears result_q, zf_q, out_valid
//   bus    exec_alu_unit_if.slave carrying operands, decode inputs and results
module exec_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    exec_alu_unit_if.slave    bus
);

    typedef enum logic [3:0] {
        SEL_AND = 4'b0000,
        SEL_OR  = 4'b0001,
        SEL_ADD = 4'b0010,
        SEL_XOR = 4'b0011,
        SEL_SUB = 4'b0110,
        SEL_SLT = 4'b0111,
        SEL_NOR = 4'b1100
    } alu_sel_e;

    alu_sel_e         sel;
    logic [WIDTH-1:0] result;
    logic             slt_bit;

    // ALU control decoder: ALUOp picks a fixed operation except for R-type,
    // where funct chooses. Every path falls back to ADD so no code yields X.
    always_comb begin
        sel = SEL_ADD;
        unique case (bus.alu_op)
            3'b000: sel = SEL_ADD;
            3'b001: sel = SEL_SUB;
            3'b010: begin
                case (bus.funct)
                    6'b100000: sel = SEL_ADD;
                    6'b100010: sel = SEL_SUB;
                    6'b100100: sel = SEL_AND;
                    6'b100101: sel = SEL_OR;
                    6'b100110: sel = SEL_XOR;
                    6'b100111: sel = SEL_NOR;
                    6'b101010: sel = SEL_SLT;
                    default:   sel = SEL_ADD;
                endcase
            end
            3'b011: sel = SEL_AND;
            3'b100: sel = SEL_OR;
            3'b101: sel = SEL_SLT;
            default: sel = SEL_ADD;
        endcase
    end

    // SLT uses a true signed compare rather than the sign of a-b, so it stays
    // correct when the subtraction would overflow.
    assign slt_bit = $signed(bus.operand_a) < $signed(bus.operand_b);

    // ALU datapath; ADD/SUB wrap silently and unused select codes act as ADD.
    always_comb begin
        result = bus.operand_a + bus.operand_b;
        case (sel)
            SEL_AND: result = bus.operand_a & bus.operand_b;
            SEL_OR:  result = bus.operand_a | bus.operand_b;
            SEL_ADD: result = bus.operand_a + bus.operand_b;
            SEL_XOR: result = bus.operand_a ^ bus.operand_b;
            SEL_SUB: result = bus.operand_a - bus.operand_b;
            SEL_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
            SEL_NOR: result = ~(bus.operand_a | bus.operand_b);
            default: result = bus.operand_a + bus.operand_b;
        endcase
    end

    assign bus.alu_sel    = sel;
    assign bus.alu_result = result;
    assign bus.zf         = (result == '0);
    assign bus.add_result = bus.add_a + bus.add_b;

    // Registered stage: capture the ALU outputs only when qualified, otherwise
    // hold them; out_valid simply tracks in_valid one cycle late. Reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.result_q  <= '0;
            bus.zf_q      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                bus.result_q <= result;
                bus.zf_q     <= (result == '0);
            end
            bus.out_valid <= bus.in_valid;
        end
    end

endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit
// Directed testbench for exec_alu_unit: decoder, ALU operations, zero flag,
// adder wrap-around and the registered stage, with hand-computed expectations.
module tb_exec_alu_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    exec_alu_unit_if #(.WIDTH(32)) bus_if ();

    exec_alu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the ALU decode inputs and operands, then let the logic settle.
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
        bus_if.alu_op    = op;
        bus_if.funct     = fn;
        bus_if.operand_a = a;
        bus_if.operand_b = b;
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.add_a    = '0;
        bus_if.add_b    = '0;
        applyStimulus(3'b000, 6'b000000, 32'd0, 32'd0);

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_result_q",  bus_if.result_q,  32'd0);
        checkOutput("rst_zf_q",      {31'd0, bus_if.zf_q},      32'd0);
        checkOutput("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type ADD
        applyStimulus(3'b010, 6'b100000, 32'd7, 32'd5);
        checkOutput("radd_sel", {28'd0, bus_if.alu_sel}, 32'h2);
        checkOutput("radd_res", bus_if.alu_result, 32'd12);
        checkOutput("radd_zf",  {31'd0, bus_if.zf}, 32'd0);

        // beq SUB, equal operands
        applyStimulus(3'b001, 6'b000000, 32'h1234, 32'h1234);
        checkOutput("beq_sel", {28'd0, bus_if.alu_sel}, 32'h6);
        checkOutput("beq_res", bus_if.alu_result, 32'd0);
        checkOutput("beq_zf",  {31'd0, bus_if.zf}, 32'd1);

        // R-type SLT: -1 < 1, and overflow-crossing MAX_INT vs MIN_INT
        applyStimulus(3'b010, 6'b101010, 32'hFFFFFFFF, 32'd1);
        checkOutput("slt_sel", {28'd0, bus_if.alu_sel}, 32'h7);
        checkOutput("slt_neg", bus_if.alu_result, 32'd1);
        checkOutput("slt_neg_zf", {31'd0, bus_if.zf}, 32'd0);
        applyStimulus(3'b010, 6'b101010, 32'h7FFFFFFF, 32'h80000000);
        checkOutput("slt_ovf", bus_if.alu_result, 32'd0);
        checkOutput("slt_ovf_zf", {31'd0, bus_if.zf}, 32'd1);

        // Logical ops via funct
        applyStimulus(3'b010, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00);
        checkOutput("and_sel", {28'd0, bus_if.alu_sel}, 32'h0);
        checkOutput("and_res", bus_if.alu_result, 32'hF000F000);
        applyStimulus(3'b010, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00);
        checkOutput("or_sel", {28'd0, bus_if.alu_sel}, 32'h1);
        checkOutput("or_res", bus_if.alu_result, 32'hFFF0FFF0);
        applyStimulus(3'b010, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00);
        checkOutput("xor_sel", {28'd0, bus_if.alu_sel}, 32'h3);
        checkOutput("xor_res", bus_if.alu_result, 32'h0FF00FF0);
        applyStimulus(3'b010, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00);
        checkOutput("nor_sel", {28'd0, bus_if.alu_sel}, 32'hC);
        checkOutput("nor_res", bus_if.alu_result, 32'h000F000F);

        // R-type SUB wraps, unknown funct defaults to ADD
        applyStimulus(3'b010, 6'b100010, 32'h80000000, 32'd1);
        checkOutput("rsub_res", bus_if.alu_result, 32'h7FFFFFFF);
        applyStimulus(3'b010, 6'b000011, 32'd9, 32'd6);
        checkOutput("rdef_sel", {28'd0, bus_if.alu_sel}, 32'h2);
        checkOutput("rdef_res", bus_if.alu_result, 32'd15);

        // Direct ALUOp codes
        applyStimulus(3'b000, 6'b100010, 32'hFFFFFFFF, 32'd2);
        checkOutput("op000_res", bus_if.alu_result, 32'd1);
        applyStimulus(3'b011, 6'b000000, 32'h0000FF0F, 32'h00000FF0);
        checkOutput("op011_res", bus_if.alu_result, 32'h00000F00);
        applyStimulus(3'b100, 6'b000000, 32'h0000FF0F, 32'h00000FF0);
        checkOutput("op100_res", bus_if.alu_result, 32'h0000FFFF);
        applyStimulus(3'b101, 6'b000000, 32'd5, 32'd3);
        checkOutput("op101_res", bus_if.alu_result, 32'd0);
        checkOutput("op101_zf",  {31'd0, bus_if.zf}, 32'd1);
        applyStimulus(3'b110, 6'b100100, 32'd20, 32'd22);
        checkOutput("op110_res", bus_if.alu_result, 32'd42);
        applyStimulus(3'b111, 6'b100111, 32'd1, 32'd1);
        checkOutput("op111_sel", {28'd0, bus_if.alu_sel}, 32'h2);
        checkOutput("op111_res", bus_if.alu_result, 32'd2);

        // Free-standing adder
        bus_if.add_a = 32'h00400004;
        bus_if.add_b = 32'hFFFFFFF8;
        #1;
        checkOutput("add_branch", bus_if.add_result, 32'h003FFFFC);
        bus_if.add_a = 32'hFFFFFFFF;
        bus_if.add_b = 32'd1;
        #1;
        checkOutput("add_wrap", bus_if.add_result, 32'd0);

        // Registered stage: in_valid pulse with result 12
        @(negedge clk);
        applyStimulus(3'b010, 6'b100000, 32'd7, 32'd5);
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reg_result_q",  bus_if.result_q, 32'd12);
        checkOutput("reg_zf_q",      {31'd0, bus_if.zf_q}, 32'd0);
        checkOutput("reg_out_valid", {31'd0, bus_if.out_valid}, 32'd1);

        // in_valid low: result_q holds while ALU output changes
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        applyStimulus(3'b001, 6'b000000, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("hold_result_q",  bus_if.result_q, 32'd12);
        checkOutput("hold_zf_q",      {31'd0, bus_if.zf_q}, 32'd0);
        checkOutput("hold_out_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Capture a zero result to see zf_q set
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("zcap_result_q", bus_if.result_q, 32'd0);
        checkOutput("zcap_zf_q",     {31'd0, bus_if.zf_q}, 32'd1);

        // Load a nonzero value, then reset together with in_valid
        @(negedge clk);
        applyStimulus(3'b000, 6'b000000, 32'd40, 32'd2);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_result_q", bus_if.result_q, 32'd42);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(3'b000, 6'b000000, 32'd100, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rstv_result_q",  bus_if.result_q, 32'd0);
        checkOutput("rstv_zf_q",      {31'd0, bus_if.zf_q}, 32'd0);
        checkOutput("rstv_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_if.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
